// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line, received-byte register, handshake and status of the UART receiver.
interface uart_rx_frame_if;
  logic       RxIn;
  logic       DataAck;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       FrameErr;
  logic       ParityErr;
  logic       Overrun;
  logic       Busy;
  modport master (
    input  RxIn, DataAck,
    output DataOut, DataValid, FrameErr, ParityErr, Overrun, Busy
  );
  modport slave (
    output RxIn, DataAck,
    input  DataOut, DataValid, FrameErr, ParityErr, Overrun, Busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver delivering bytes through a valid/ack register.
// Defining UART_RX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic            Clk,
  input  logic            Rst,
  uart_rx_frame_if.master bus
);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d, dout_q, dout_d;
  logic        valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic        load;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d, perr_q, perr_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    ferr_d  = 1'b0;
    load    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = bus.RxIn ? IDLE : START;
      end
      START: if (cnt_q == HALF_END) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = bus.RxIn ? IDLE : DATA;
      end
      DATA: if (cnt_q == BIT_END) begin
        cnt_d = '0;
        sh_d  = {bus.RxIn, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        par_d   = bus.RxIn;
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == BIT_END) begin
        cnt_d   = '0;
        load    = bus.RxIn;
        ferr_d  = ~bus.RxIn;
        state_d = bus.RxIn ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d   = '0;
        state_d = bus.RxIn ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
    // a load coinciding with an ack is a clean handover, not an overrun
    dout_d  = load ? sh_q : dout_q;
    valid_d = load | (valid_q & ~bus.DataAck);
    ovr_d   = ~bus.DataAck & (ovr_q | (load & valid_q));
`ifdef UART_RX_PARITY_EN
    perr_d  = load & (par_q ^ (^sh_q));
`endif
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  assign bus.DataOut   = dout_q;
  assign bus.DataValid = valid_q;
  assign bus.FrameErr  = ferr_q;
  assign bus.Overrun   = ovr_q;
  assign bus.Busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign bus.ParityErr = perr_q;
`else
  assign bus.ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed and random frames checked every cycle against an edge-offset reference model.
module tb_uart_rx_frame;
  localparam int N = 16;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB   = PAR ? 11 : 10;
  localparam int RISE = PAR ? 169 : 153;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_frame_if bus();
  uart_rx_frame #(.CLKS_PER_BIT(N)) dut (.Clk(clk), .Rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // reference: every sample point is an absolute offset from the edge that saw the start bit
  int e = 0, k = 0, mode = 0, off = 0;
  logic [7:0] m_byte = '0, m_dout = '0;
  logic m_par = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_load = 1'b0;
  always @(posedge clk) begin
    e++;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    m_load = 1'b0;
    if (rst) begin
      mode = 0; m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      if (mode == 0) begin
        if (!bus.RxIn) begin k = e; mode = 1; end
      end else if (mode == 2) begin
        if (bus.RxIn) mode = 0;
      end else begin
        off = e - k;
        if (off == H && bus.RxIn) mode = 0;
        for (int i = 0; i < 8; i++) if (off == H + (i + 1) * N) m_byte[i] = bus.RxIn;
        if (PAR && off == H + 9 * N) m_par = bus.RxIn;
        if (mode == 1 && off == H + (NB - 1) * N) begin
          if (bus.RxIn) begin
            m_load = 1'b1; mode = 0;
            m_perr = PAR && (m_par != ^m_byte);
          end else begin
            m_ferr = 1'b1; mode = 2;
          end
        end
      end
      if (m_load) begin
        m_ovr = (m_valid || m_ovr) && !bus.DataAck;
        m_dout = m_byte; m_valid = 1'b1;
      end else if (bus.DataAck) begin
        m_valid = 1'b0; m_ovr = 1'b0;
      end
    end
  end
  int n_cmp = 0, n_bad = 0;
  int busy_cnt = 0, ferr_cnt = 0, perr_cnt = 0, rises = 0, rise_edge = 0, k_last = 0;
  bit go = 1'b0, rand_en = 1'b0;
  logic pv = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (go) begin
      chk("DataOut", 32'(bus.DataOut), 32'(m_dout));
      chk("DataValid", 32'(bus.DataValid), 32'(m_valid));
      chk("FrameErr", 32'(bus.FrameErr), 32'(m_ferr));
      chk("ParityErr", 32'(bus.ParityErr), 32'(m_perr));
      chk("Overrun", 32'(bus.Overrun), 32'(m_ovr));
      chk("Busy", 32'(bus.Busy), 32'(mode != 0));
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.FrameErr === 1'b1) ferr_cnt++;
      if (bus.ParityErr === 1'b1) perr_cnt++;
      if (bus.DataValid === 1'b1 && !pv) begin rises++; rise_edge = cyc + 1; end
      pv = bus.DataValid;
    end
  endtask
  task automatic drive(input logic v, input int n);
    bus.RxIn = v;
    repeat (n) begin
      bus.DataAck = rand_en && ($urandom_range(0, 7) == 0);
      tick();
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic par);
    logic [10:0] fr;
    fr = PAR ? {stop, par, b, 1'b0} : {1'b1, stop, b, 1'b0};
    k_last = cyc + 1;
    for (int i = 0; i < NB; i++) drive(fr[i], N);
  endtask
  task automatic ack();
    bus.DataAck = 1'b1;
    tick();
    bus.DataAck = 1'b0;
  endtask
  initial begin
    int b0, f0, r0, p0;
    logic [7:0] b;
    logic stop;
    bus.RxIn = 1'b1;
    bus.DataAck = 1'b0;
    tick();
    go = 1'b1;
    tick();
    chk("rst_dout", 32'(bus.DataOut), 32'h0);
    chk("rst_valid", 32'(bus.DataValid), 32'h0);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_ovr", 32'(bus.Overrun), 32'h0);
    rst = 1'b0;
    drive(1'b1, 5);
    send(8'hA5, 1'b1, ^8'hA5);
    drive(1'b1, 4);
    chk("a5_data", 32'(bus.DataOut), 32'hA5);
    chk("a5_rise", 32'(rise_edge - k_last), 32'(RISE));
    chk("a5_busy", 32'(bus.Busy), 32'h0);
    ack();
    b0 = busy_cnt; r0 = rises;
    drive(1'b0, 3);
    drive(1'b1, 20);
    chk("false_busy_cycles", 32'(busy_cnt - b0), 32'd8);
    chk("false_no_valid", 32'(rises - r0), 32'd0);
    f0 = ferr_cnt; r0 = rises;
    send(8'h5A, 1'b0, ^8'h5A);
    drive(1'b0, 40);
    chk("break_busy", 32'(bus.Busy), 32'h1);
    drive(1'b1, 8);
    chk("break_idle", 32'(bus.Busy), 32'h0);
    chk("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_no_load", 32'(rises - r0), 32'd0);
    send(8'h3C, 1'b1, ^8'h3C);
    drive(1'b1, 4);
    chk("after_break_data", 32'(bus.DataOut), 32'h3C);
    chk("after_break_valid", 32'(bus.DataValid), 32'h1);
    ack();
    send(8'h11, 1'b1, ^8'h11);
    send(8'h22, 1'b1, ^8'h22);
    drive(1'b1, 4);
    chk("ovr_data", 32'(bus.DataOut), 32'h22);
    chk("ovr_set", 32'(bus.Overrun), 32'h1);
    ack();
    chk("ack_valid", 32'(bus.DataValid), 32'h0);
    chk("ack_ovr", 32'(bus.Overrun), 32'h0);
`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    send(8'h07, 1'b1, 1'b0);
    drive(1'b1, 4);
    chk("par_bad_pulse", 32'(perr_cnt - p0), 32'd1);
    chk("par_bad_data", 32'(bus.DataOut), 32'h07);
    chk("par_bad_valid", 32'(bus.DataValid), 32'h1);
    ack();
    p0 = perr_cnt;
    send(8'h07, 1'b1, 1'b1);
    drive(1'b1, 4);
    chk("par_ok_pulse", 32'(perr_cnt - p0), 32'd0);
    ack();
`else
    p0 = perr_cnt;
`endif
    b = 8'hC3;
    k_last = cyc + 1;
    drive(1'b0, N);
    for (int i = 0; i < 4; i++) drive(b[i], N);
    drive(b[4], 8);
    bus.RxIn = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bus.Busy), 32'h0);
    chk("mid_rst_valid", 32'(bus.DataValid), 32'h0);
    chk("mid_rst_dout", 32'(bus.DataOut), 32'h0);
    drive(1'b1, 4);
    send(8'hC3, 1'b1, ^8'hC3);
    drive(1'b1, 4);
    chk("c3_data", 32'(bus.DataOut), 32'hC3);
    chk("c3_valid", 32'(bus.DataValid), 32'h1);
    rand_en = 1'b1;
    repeat (30) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 5) != 0;
      send(b, stop, (^b) ^ ($urandom_range(0, 3) == 0));
      if (!stop) drive(1'b0, $urandom_range(0, 30));
      drive(1'b1, $urandom_range(1, 6));
    end
    rand_en = 1'b0;
    drive(1'b1, N);
    chk("parity_pulses_total", 32'(PAR ? 0 : perr_cnt - p0), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
